// File: rtl/cnn_pkg.sv
// Shared constants, types and helpers for the MNIST CNN pipeline.
package cnn_pkg;

  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int K        = 5;
  localparam int PIX_BITS = 8;
  localparam int W_BITS   = 8;
  localparam int ACT_BITS = 12;
  localparam int ACC_BITS = 24;

  typedef logic signed [ACT_BITS-1:0] act_t;

  typedef enum logic [1:0] {
    WIN_PRIME = 2'd0,
    WIN_RUN   = 2'd1,
    WIN_DONE  = 2'd2
  } win_state_e;

  localparam act_t ACT_MAX = 12'sh7FF;
  localparam act_t ACT_MIN = 12'sh800;
  localparam logic signed [ACC_BITS-1:0] ACC_ACT_MAX = 24'sd2047;
  localparam logic signed [ACC_BITS-1:0] ACC_ACT_MIN = -24'sd2048;

  function automatic act_t sat_act(input logic signed [ACC_BITS-1:0] v);
    act_t r;
    if (v > ACC_ACT_MAX) begin
      r = ACT_MAX;
    end else if (v < ACC_ACT_MIN) begin
      r = ACT_MIN;
    end else begin
      r = v[ACT_BITS-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_conv1_core_if.sv
// Pixel-in / three-channel-result bundle between stage feeders and conv1.
interface cnn_conv1_core_if
  import cnn_pkg::*;
();
  logic [PIX_BITS-1:0] data_in;
  act_t                conv_out_1;
  act_t                conv_out_2;
  act_t                conv_out_3;
  logic                valid_out_conv;

  modport slave (
    input  data_in,
    output conv_out_1, conv_out_2, conv_out_3, valid_out_conv
  );

  modport master (
    output data_in,
    input  conv_out_1, conv_out_2, conv_out_3, valid_out_conv
  );
endinterface

// File: rtl/conv_window_buffer.sv
// Raster-stream line buffer: keeps the last (K-1)*WIDTH+K pixels and flags
// each cycle in which a complete KxK window has just been sampled.
module conv_window_buffer
  import cnn_pkg::*;
#(
  parameter int WIDTH     = IMG_W,
  parameter int HEIGHT    = IMG_H,
  parameter int KS        = cnn_pkg::K,
  parameter int DATA_BITS = PIX_BITS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_BITS-1:0]               data_in,
  output logic [KS*KS-1:0][DATA_BITS-1:0]    taps,
  output logic                               window_ready
);

  localparam int BUF_LEN = (KS - 1) * WIDTH + KS;
  localparam int CW      = $clog2(WIDTH);
  localparam int RW      = $clog2(HEIGHT);

  win_state_e                          state_q, state_d;
  logic [CW-1:0]                       col_q, col_d;
  logic [RW-1:0]                       row_q, row_d;
  logic                                ready_q, ready_d;
  logic [BUF_LEN-1:0][DATA_BITS-1:0]   buf_q, buf_d;

  // Control state: priming cycle, raster counters, window-complete strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WIN_PRIME;
      col_q   <= '0;
      row_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ready_q <= ready_d;
    end
  end

  // Pixel history; contents are don't-care until a full window has arrived.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // Next-state: the first post-reset sample is discarded, then one image is taken.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ready_d = 1'b0;
    buf_d   = buf_q;
    case (state_q)
      WIN_PRIME: begin
        state_d = WIN_RUN;
      end
      WIN_RUN: begin
        buf_d   = {buf_q[BUF_LEN-2:0], data_in};
        ready_d = (row_q >= RW'(KS - 1)) && (col_q >= CW'(KS - 1));
        if (col_q == CW'(WIDTH - 1)) begin
          col_d = '0;
          if (row_q == RW'(HEIGHT - 1)) begin
            row_d   = '0;
            state_d = WIN_DONE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      WIN_DONE: begin
        state_d = WIN_DONE;
      end
      default: begin
        state_d = WIN_PRIME;
      end
    endcase
  end

  // Tap (i,j) of the window sits (K-1-i) rows and (K-1-j) columns behind the newest pixel.
  always_comb begin
    taps = '0;
    for (int i = 0; i < KS; i++) begin
      for (int j = 0; j < KS; j++) begin
        taps[i*KS + j] = buf_q[(KS - 1 - i) * WIDTH + (KS - 1 - j)];
      end
    end
  end

  assign window_ready = ready_q;

endmodule

// File: rtl/cnn_conv1_core.sv
// Conv1 stage: 5x5 valid convolution of a 28x28 pixel stream into three
// saturated 12-bit channels, one result per completed window.
module cnn_conv1_core
  import cnn_pkg::*;
#(
  parameter int WIDTH     = IMG_W,
  parameter int HEIGHT    = IMG_H,
  parameter int K         = cnn_pkg::K,
  parameter int DATA_BITS = PIX_BITS,
  parameter int OUT_BITS  = ACT_BITS,
  parameter int SHIFT     = 8,
  parameter logic [K*K*DATA_BITS-1:0] W1 = '0,
  parameter logic [K*K*DATA_BITS-1:0] W2 = '0,
  parameter logic [K*K*DATA_BITS-1:0] W3 = '0,
  parameter logic [3*DATA_BITS-1:0]   B  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  cnn_conv1_core_if.slave   bus
);

  // Weight ROM: tap t of channel n at [(n*K*K + t)*DATA_BITS +: DATA_BITS], row-major.
  localparam logic [3*K*K*DATA_BITS-1:0] W_ALL = {W3, W2, W1};
  localparam int EXT = ACC_BITS - DATA_BITS;

  logic [K*K-1:0][DATA_BITS-1:0] taps;
  logic                          window_ready;
  logic                          valid_q, valid_d;

  conv_window_buffer #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .KS        (K),
    .DATA_BITS (DATA_BITS)
  ) u_window (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (bus.data_in),
    .taps         (taps),
    .window_ready (window_ready)
  );

  for (genvar n = 0; n < 3; n++) begin : g_lane
    logic signed [ACC_BITS-1:0] sum;
    logic signed [ACC_BITS-1:0] y;
    logic [DATA_BITS-1:0]       w_tap;
    logic [DATA_BITS-1:0]       b_raw;
    logic signed [OUT_BITS-1:0] out_d, out_q;

    // Pixels are unsigned, weights signed: zero- vs sign-extend before the multiply.
    always_comb begin
      sum   = '0;
      w_tap = '0;
      for (int t = 0; t < K*K; t++) begin
        w_tap = W_ALL[(n*K*K + t)*DATA_BITS +: DATA_BITS];
        sum   = sum + ($signed({{EXT{1'b0}}, taps[t]}) *
                       $signed({{EXT{w_tap[DATA_BITS-1]}}, w_tap}));
      end
      b_raw = B[n*DATA_BITS +: DATA_BITS];
      y     = (sum >>> SHIFT) + $signed({{EXT{b_raw[DATA_BITS-1]}}, b_raw});
      if (window_ready) begin
        out_d = sat_act(y);
      end else begin
        out_d = out_q;
      end
    end

    // Lane result register; holds between windows.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_q <= '0;
      end else begin
        out_q <= out_d;
      end
    end
  end

  // Valid strobe trails the window-complete strobe by one edge, aligned with results.
  always_comb begin
    valid_d = window_ready;
  end

  // Output valid register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign bus.conv_out_1     = g_lane[0].out_q;
  assign bus.conv_out_2     = g_lane[1].out_q;
  assign bus.conv_out_3     = g_lane[2].out_q;
  assign bus.valid_out_conv = valid_q;

endmodule

// File: tb/tb_cnn_conv1_core.sv
// Randomized bench for cnn_conv1_core: three differently configured instances
// share one pixel stream and are compared every cycle against an arithmetic model.
module tb_cnn_conv1_core;
  import cnn_pkg::*;

  localparam int NPIX = 784;

  localparam logic [199:0] W_MIX1 = 200'h05FB10F07F8001FF22DE33CC0011EE44BB55AA6699778812ED;
  localparam logic [199:0] W_MIX2 = 200'h3CC402FE19E70040C008F821DF0FF17E812AD605FB13ED01FF;
  localparam logic [199:0] W_ZERO = 200'd0;
  localparam logic [199:0] W_CTR  = 200'd1 << 96;
  localparam logic [199:0] W_127  = {25{8'h7F}};
  localparam logic [199:0] W_N128 = {25{8'h80}};
  localparam logic [199:0] W_ONE  = {25{8'h01}};
  localparam logic [199:0] W_NEG1 = {25{8'hFF}};
  localparam logic [23:0]  B_A    = {8'h05, 8'hFD, 8'hF9};
  localparam logic [23:0]  B_B    = 24'h000000;
  localparam logic [23:0]  B_C    = {8'h03, 8'hFF, 8'hFF};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'd0;

  int n_checks = 0;
  int n_errors = 0;

  int img [NPIX];
  int wt [3][3][25];
  int bs [3][3];
  int sh [3];
  int last_exp [3][3];

  always #5 clk = ~clk;

  cnn_conv1_core_if if_a ();
  cnn_conv1_core_if if_b ();
  cnn_conv1_core_if if_c ();
  assign if_a.data_in = data_in;
  assign if_b.data_in = data_in;
  assign if_c.data_in = data_in;

  cnn_conv1_core #(.SHIFT(8), .W1(W_MIX1), .W2(W_ZERO), .W3(W_127),  .B(B_A))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  cnn_conv1_core #(.SHIFT(0), .W1(W_CTR),  .W2(W_127),  .W3(W_N128), .B(B_B))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  cnn_conv1_core #(.SHIFT(2), .W1(W_ONE),  .W2(W_NEG1), .W3(W_MIX2), .B(B_C))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void load_cfg(input int d, input logic [199:0] w1, input logic [199:0] w2,
                                   input logic [199:0] w3, input logic [23:0] b, input int s);
    for (int t = 0; t < 25; t++) begin
      wt[d][0][t] = int'($signed(w1[t*8 +: 8]));
      wt[d][1][t] = int'($signed(w2[t*8 +: 8]));
      wt[d][2][t] = int'($signed(w3[t*8 +: 8]));
    end
    for (int ch = 0; ch < 3; ch++) bs[d][ch] = int'($signed(b[ch*8 +: 8]));
    sh[d] = s;
  endfunction

  // Convolution result for window top-left (r,c) straight from the arithmetic definition.
  function automatic int ref_conv(input int d, input int ch, input int r, input int c);
    int acc = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        acc += img[(r + i) * 28 + c + j] * wt[d][ch][i*5 + j];
    acc = (acc >>> sh[d]) + bs[d][ch];
    if (acc > 2047) acc = 2047;
    if (acc < -2048) acc = -2048;
    return acc;
  endfunction

  function automatic int obs_out(input int d, input int ch);
    case (d*3 + ch)
      0: return int'(if_a.conv_out_1);
      1: return int'(if_a.conv_out_2);
      2: return int'(if_a.conv_out_3);
      3: return int'(if_b.conv_out_1);
      4: return int'(if_b.conv_out_2);
      5: return int'(if_b.conv_out_3);
      6: return int'(if_c.conv_out_1);
      7: return int'(if_c.conv_out_2);
      8: return int'(if_c.conv_out_3);
      default: return 0;
    endcase
  endfunction

  function automatic int obs_valid(input int d);
    case (d)
      0: return int'(if_a.valid_out_conv);
      1: return int'(if_b.valid_out_conv);
      2: return int'(if_c.valid_out_conv);
      default: return 0;
    endcase
  endfunction

  // Called at a falling edge; applies a one-cycle reset, then streams one image.
  task automatic run_image(input int pat, input int abort_at);
    int  first_e = 0;
    int  nvalid  = 0;
    int  p, r, c;
    bit  exp_v;
    for (int k = 0; k < NPIX; k++) begin
      case (pat)
        1: img[k] = k % 256;
        2: img[k] = 255;
        3: img[k] = 1;
        default: img[k] = int'($urandom_range(0, 255));
      endcase
    end
    rst_n   = 1'b0;
    data_in = 8'($urandom_range(0, 255));
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_val($sformatf("rst_valid_d%0d", d), obs_valid(d), 0);
      for (int ch = 0; ch < 3; ch++) begin
        check_val($sformatf("rst_out_d%0d_ch%0d", d, ch + 1), obs_out(d, ch), 0);
        last_exp[d][ch] = 0;
      end
    end
    rst_n   = 1'b1;
    data_in = 8'($urandom_range(0, 255));
    for (int e = 1; e <= 800; e++) begin
      @(posedge clk);
      @(negedge clk);
      p     = e - 3;
      exp_v = (p >= 0) && (p < NPIX) && (p / 28 >= 4) && (p % 28 >= 4);
      r = 0;
      c = 0;
      if (exp_v) begin
        nvalid++;
        if (first_e == 0) first_e = e;
        r = p / 28 - 4;
        c = p % 28 - 4;
        for (int d = 0; d < 3; d++)
          for (int ch = 0; ch < 3; ch++)
            last_exp[d][ch] = ref_conv(d, ch, r, c);
      end
      for (int d = 0; d < 3; d++) begin
        check_val($sformatf("valid_d%0d_e%0d", d, e), obs_valid(d), int'(exp_v));
        for (int ch = 0; ch < 3; ch++)
          check_val($sformatf("out_d%0d_ch%0d_e%0d", d, ch + 1, e), obs_out(d, ch), last_exp[d][ch]);
      end
      if (exp_v && r == 0 && c == 0) begin
        check_val("zero_weight_bias", obs_out(0, 1), -3);
        if (pat == 1) check_val("centre_first", obs_out(1, 0), 58);
        if (pat == 2) begin
          check_val("sat_pos", obs_out(1, 1), 2047);
          check_val("sat_neg", obs_out(1, 2), -2048);
        end
        if (pat == 3) begin
          check_val("shift_bias_pos", obs_out(2, 0), 5);
          check_val("shift_bias_neg", obs_out(2, 1), -8);
        end
      end
      if (abort_at >= 0 && e - 1 == abort_at) return;
      if (e - 1 < NPIX) data_in = 8'(img[e - 1]);
      else data_in = 8'($urandom_range(0, 255));
    end
    check_val("valid_count", nvalid, 576);
    check_val("first_valid_edge", first_e, 119);
  endtask

  initial begin
    load_cfg(0, W_MIX1, W_ZERO, W_127,  B_A, 8);
    load_cfg(1, W_CTR,  W_127,  W_N128, B_B, 0);
    load_cfg(2, W_ONE,  W_NEG1, W_MIX2, B_C, 2);
    @(negedge clk);
    run_image(0, -1);
    run_image(1, -1);
    run_image(2, -1);
    run_image(3, -1);
    run_image(0, 300);
    run_image(0, -1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
